// File: rtl/stim_seq_pkg.sv
// Shared types and sizing helpers for the characterization phase sequencer.
package stim_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        TRANS = 2'd2
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stim_next_phase.sv
// Priority search over the phase-enable mask: the next enabled phase above
// the current one, plus the lowest enabled phase for wrap and run start.
module stim_next_phase
    import stim_seq_pkg::*;
#(
    parameter  int N_PHASES = 4,
    localparam int IW       = width_of(N_PHASES)
) (
    input  logic [N_PHASES-1:0] en,
    input  logic [IW-1:0]       cur,
    output logic [IW-1:0]       next_idx,
    output logic                next_found,
    output logic [IW-1:0]       first_idx,
    output logic                any_en
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        next_idx   = '0;
        next_found = 1'b0;
        first_idx  = '0;
        any_en     = 1'b0;
        // Descending scan: the last hit wins, giving the lowest qualifying index.
        for (int i = N_PHASES - 1; i >= 0; i--) begin
            if (en[i]) begin
                first_idx = IW'(i);
                any_en    = 1'b1;
                if (i > int'(cur)) begin
                    next_idx   = IW'(i);
                    next_found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stim_phase_seq.sv
// Programmable setup/transition stimulus player with per-phase response
// checking, used for gate delay characterization and as a BIST source.
module stim_phase_seq
    import stim_seq_pkg::*;
#(
    parameter  int N_IN       = 4,
    parameter  int N_OUT      = 1,
    parameter  int N_PHASES   = 4,
    parameter  int SETTLE_CYC = 4,
    parameter  int VALID_CYC  = 8,
    localparam int IW         = width_of(N_PHASES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      loop_en,
    input  logic [N_PHASES-1:0]       phase_en,
    input  logic [N_PHASES*N_IN-1:0]  init_vec,
    input  logic [N_PHASES*N_IN-1:0]  final_vec,
    input  logic [N_PHASES*N_OUT-1:0] exp_vec,
    input  logic [N_OUT-1:0]          dut_out,
    output logic [N_IN-1:0]           stim,
    output logic                      valid,
    output logic [IW-1:0]             phase_idx,
    output logic                      busy,
    output logic                      done,
    output logic [N_PHASES-1:0]       err
);

    localparam int CNT_MAX = (SETTLE_CYC > VALID_CYC) ? SETTLE_CYC : VALID_CYC;
    localparam int CW      = width_of(CNT_MAX + 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   next_idx;
    logic [IW-1:0]   first_idx;
    logic            next_found;
    logic            any_en;
    logic            adv_ok;
    logic [IW-1:0]   adv_idx;

    stim_next_phase #(.N_PHASES(N_PHASES)) u_next (
        .en         (phase_en),
        .cur        (phase_idx),
        .next_idx   (next_idx),
        .next_found (next_found),
        .first_idx  (first_idx),
        .any_en     (any_en)
    );

    // Continue with a higher phase, or wrap to the lowest one when looping.
    assign adv_ok  = next_found | (loop_en & any_en);
    assign adv_idx = next_found ? next_idx : first_idx;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below reads the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            stim      <= '0;
            valid     <= 1'b0;
            phase_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                cnt   <= '0;
                valid <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            err <= '0;
                            if (any_en) begin
                                phase_idx <= first_idx;
                                stim      <= init_vec[int'(first_idx)*N_IN +: N_IN];
                                busy      <= 1'b1;
                                state     <= SETUP;
                                cnt       <= CW'(SETTLE_CYC - 1);
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end

                    SETUP: begin
                        if (cnt == '0) begin
                            state <= TRANS;
                            stim  <= final_vec[int'(phase_idx)*N_IN +: N_IN];
                            valid <= 1'b1;
                            cnt   <= CW'(VALID_CYC - 1);
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end

                    TRANS: begin
                        if (cnt == '0) begin
                            if (dut_out != exp_vec[int'(phase_idx)*N_OUT +: N_OUT])
                                err[phase_idx] <= 1'b1;
                            valid <= 1'b0;
                            if (adv_ok) begin
                                phase_idx <= adv_idx;
                                stim      <= init_vec[int'(adv_idx)*N_IN +: N_IN];
                                state     <= SETUP;
                                cnt       <= CW'(SETTLE_CYC - 1);
                            end else begin
                                state <= IDLE;
                                cnt   <= '0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
